sequence_generator: RTL and testbench

- Serial pattern transmitter; the transmit-side counterpart of the team's serial sequence detector.
- On a start request, shifts a fixed PAT_WIDTH-bit pattern out MSB-first, one bit per clock, for a programmable number of back-to-back repetitions.
- Used to drive the detector's in_bit and to generate serial stimulus on-chip.
- Registered outputs; valid/busy/done status toward the controlling logic.

---
 rtl/sequence_generator_if.sv | 14 +
 rtl/sequence_generator.sv | 87 ++++++++
 tb/tb_sequence_generator.sv | 111 +++++++++++
 3 files changed

// File: rtl/sequence_generator_if.sv
// sequence_generator_if: control and serial-output signals of the pattern transmitter.
interface sequence_generator_if #(
    parameter int CNT_WIDTH = 4
);
    logic                 start;
    logic [CNT_WIDTH-1:0] rep_count;
    logic                 abort;
    logic                 out_bit;
    logic                 out_valid;
    logic                 busy;
    logic                 done;
    modport master (output start, rep_count, abort, input out_bit, out_valid, busy, done);
    modport slave (input start, rep_count, abort, output out_bit, out_valid, busy, done);
endinterface

// File: rtl/sequence_generator.sv
// sequence_generator: shifts PATTERN out MSB-first for rep_count back-to-back repetitions.
// Defining SEQ_GEN_PARITY_EN appends an even-parity bit after every repetition.
module sequence_generator #(
    parameter int                   PAT_WIDTH = 7,
    parameter logic [PAT_WIDTH-1:0] PATTERN   = 7'b0110110,
    parameter int                   CNT_WIDTH = 4,
    parameter logic                 IDLE_BIT  = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    sequence_generator_if.slave sif
);
    localparam int IW = $clog2(PAT_WIDTH);
    localparam logic [IW-1:0] TOP = IW'(PAT_WIDTH - 1);
`ifdef SEQ_GEN_PARITY_EN
    localparam logic PAR_BIT = ^PATTERN;
    typedef enum logic [1:0] {IDLE, SEND, DONE, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif
    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [CNT_WIDTH-1:0] rep, rep_n;
    logic                 bit_n, valid_n;
    always_comb begin
        state_n = state;
        idx_n   = idx;
        rep_n   = rep;
        case (state)
            IDLE: if (sif.start) begin
                state_n = sif.rep_count != '0 ? SEND : DONE;
                rep_n   = sif.rep_count;
                idx_n   = TOP;
            end
            SEND: if (sif.abort) begin
                state_n = IDLE;
                idx_n   = TOP;
                rep_n   = '0;
            end else if (idx == '0) begin
                // the repetition just finished is retired on its last bit
                rep_n   = rep - CNT_WIDTH'(1);
                idx_n   = TOP;
`ifdef SEQ_GEN_PARITY_EN
                state_n = PAR;
`else
                state_n = rep_n != '0 ? SEND : DONE;
`endif
            end else begin
                idx_n = idx - IW'(1);
            end
`ifdef SEQ_GEN_PARITY_EN
            PAR: begin
                state_n = sif.abort ? IDLE : (rep != '0 ? SEND : DONE);
                rep_n   = sif.abort ? '0 : rep;
            end
`endif
            default: state_n = IDLE;
        endcase
`ifdef SEQ_GEN_PARITY_EN
        valid_n = state_n == SEND || state_n == PAR;
        bit_n   = state_n == SEND ? PATTERN[idx_n] : (state_n == PAR ? PAR_BIT : IDLE_BIT);
`else
        valid_n = state_n == SEND;
        bit_n   = state_n == SEND ? PATTERN[idx_n] : IDLE_BIT;
`endif
    end
    // outputs are registered from next-state values so they align with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= TOP;
            rep           <= '0;
            sif.out_bit   <= IDLE_BIT;
            sif.out_valid <= 1'b0;
            sif.busy      <= 1'b0;
            sif.done      <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            rep           <= rep_n;
            sif.out_bit   <= bit_n;
            sif.out_valid <= valid_n;
            sif.busy      <= state_n != IDLE;
            sif.done      <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed transfers of the serial pattern transmitter with per-cycle checks.
module tb_sequence_generator;
    localparam int PW = 7;
`ifdef SEQ_GEN_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int G = PW + PB;
    logic clk = 1'b0;
    logic rst;
    int errors = 0;
    int checks = 0;
    int dets = 0;
    logic [6:0] sr = '0;
    logic [6:0] pat = 7'b0110110;
    sequence_generator_if #(.CNT_WIDTH(4)) sif ();
    sequence_generator dut (.clk(clk), .rst(rst), .sif(sif));
    always #5 clk = ~clk;
    // reference detector fed by the serial stream
    always @(posedge clk) begin
        if (sif.out_valid) begin
            sr <= {sr[5:0], sif.out_bit};
            if ({sr[5:0], sif.out_bit} == 7'b0110110) dets <= dets + 1;
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check_idle(input string tag);
        check({tag, " valid"}, 32'(sif.out_valid), 0);
        check({tag, " bit"}, 32'(sif.out_bit), 0);
        check({tag, " busy"}, 32'(sif.busy), 0);
        check({tag, " done"}, 32'(sif.done), 0);
    endtask
    function automatic logic exp_bit(input int k);
        return k < PW ? pat[PW-1-k] : ^pat;
    endfunction
    // kill_at: cycle in which abort (or rst) is held; glitch_at: cycle with a stray start (-1 = done cycle)
    task automatic xfer(input int n, input int kill_at, input bit kill_rst, input int glitch_at, input bit ab_start);
        int t = n * G;
        int ga = glitch_at < 0 ? t + 1 : glitch_at;
        string tg;
        sif.start = 1'b1;
        sif.rep_count = 4'(n);
        sif.abort = ab_start;
        tick();
        sif.start = 1'b0;
        sif.abort = 1'b0;
        sif.rep_count = ~4'(n);
        for (int c = 1; c <= t + 2; c++) begin
            tg = $sformatf("n%0d c%0d", n, c);
            check({tg, " valid"}, 32'(sif.out_valid), 32'(c <= t));
            check({tg, " bit"}, 32'(sif.out_bit), c <= t ? 32'(exp_bit((c - 1) % G)) : 0);
            check({tg, " busy"}, 32'(sif.busy), 32'(c <= t + 1));
            check({tg, " done"}, 32'(sif.done), 32'(c == t + 1));
            if (c == t + 2) break;
            if (c == kill_at) begin
                if (kill_rst) rst = 1'b1;
                else sif.abort = 1'b1;
            end
            if (c == ga) sif.start = 1'b1;
            tick();
            sif.start = 1'b0;
            sif.abort = 1'b0;
            if (c == kill_at) begin
                rst = 1'b0;
                check_idle($sformatf("n%0d kill c%0d", n, c + 1));
                return;
            end
        end
    endtask
    initial begin
        int d0;
        rst = 1'b1;
        sif.start = 1'b1;
        sif.abort = 1'b1;
        sif.rep_count = 4'd3;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        sif.start = 1'b0;
        tick();
        check_idle("abort idle");
        sif.abort = 1'b0;
        xfer(1, 0, 0, 0, 0);
        xfer(3, 0, 0, 0, 0);
        xfer(0, 0, 0, 0, 0);
        xfer(2, 0, 0, 4, 0);
        xfer(1, 0, 0, -1, 0);
        xfer(2, 3, 0, 0, 0);
        xfer(2, G, 0, 0, 0);
        xfer(2, 5, 1, 0, 0);
        xfer(1, 0, 0, 0, 1);
        xfer(15, 0, 0, 0, 0);
        d0 = dets;
        xfer(2, 0, 0, 0, 0);
        check("loopback detections", 32'(dets - d0), 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
